// File: rtl/dbx_encoder_pkg.sv
// Shared DBX geometry and bit-ordering helpers, used by both encoder and decoder.
// Byte r occupies the top-down byte slot r; plane k occupies the top-down 32-bit slot k.
package dbx_encoder_pkg;
  localparam int DBX_NUM_SYM = 32;
  localparam int DBX_SYM_W   = 8;
  localparam int DBX_BLK_W   = DBX_NUM_SYM * DBX_SYM_W;

  // bit index of symbol r, column k (column 0 = byte msb)
  function automatic int sym_bit(input int r, input int k);
    return DBX_BLK_W - 1 - DBX_SYM_W * r - k;
  endfunction

  // bit index of plane k, symbol r (symbol 0 = plane msb)
  function automatic int plane_bit(input int k, input int r);
    return DBX_BLK_W - 1 - DBX_NUM_SYM * k - r;
  endfunction

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/dbx_plane_xform.sv
// Combinational transpose of 32 delta bytes into 8 bitplanes, each XORed with its
// predecessor plane except for the root column, which stays raw so the decoder can seed.
module dbx_plane_xform
  import dbx_encoder_pkg::*;
(
  input  logic [DBX_BLK_W-1:0] diff,
  output logic [DBX_BLK_W-1:0] bpx
);
  for (genvar k = 0; k < DBX_SYM_W; k++) begin : g_plane
    for (genvar r = 0; r < DBX_NUM_SYM; r++) begin : g_sym
      if (k == 0 || r == 0) begin : g_raw
        assign bpx[plane_bit(k, r)] = diff[sym_bit(r, k)];
      end else begin : g_xor
        assign bpx[plane_bit(k, r)] = diff[sym_bit(r, k)] ^ diff[sym_bit(r, k - 1)];
      end
    end
  end
endmodule

// File: rtl/dbx_encoder.sv
// DBX encoder: xform -> S1 register -> S2 register with per-plane zero flags and count.
// Two-entry valid/ready pipeline; S2 can drain and S1 refill in the same cycle.
module dbx_encoder
  import dbx_encoder_pkg::*;
#(
  parameter int NUM_SYM = 32,
  parameter int SYM_W   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [NUM_SYM*SYM_W-1:0] diff_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [NUM_SYM*SYM_W-1:0] bpx_o,
  output logic [SYM_W-1:0]         zero_plane_o,
  output logic [3:0]               zero_cnt_o,
  output logic [TAG_W-1:0]         tag_o
);
  localparam int BLK_W = NUM_SYM * SYM_W;

  logic [BLK_W-1:0] bpx_c, s1_bpx;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_v, s1_adv, s2_adv;
  logic [SYM_W-1:0] zp_c;

  assign s2_adv  = !valid_o || ready_i;
  assign s1_adv  = !s1_v || s2_adv;
  assign ready_o = s1_adv;

  dbx_plane_xform u_xform (
    .diff (diff_i),
    .bpx  (bpx_c)
  );

  always_ff @(posedge clk) begin
    if (rst)         s1_v <= 1'b0;
    else if (s1_adv) s1_v <= valid_i;
  end

  // payload only moves with a real accept, so no reset needed
  always_ff @(posedge clk) begin
    if (s1_adv && valid_i) begin
      s1_bpx <= bpx_c;
      s1_tag <= tag_i;
    end
  end

  always_comb begin
    zp_c = '0;
    for (int k = 0; k < SYM_W; k++)
      zp_c[k] = ~|s1_bpx[BLK_W-1-NUM_SYM*k -: NUM_SYM];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= 1'b0;
      bpx_o        <= '0;
      zero_plane_o <= '0;
      zero_cnt_o   <= '0;
      tag_o        <= '0;
    end else if (s2_adv) begin
      valid_o <= s1_v;
      if (s1_v) begin
        bpx_o        <= s1_bpx;
        zero_plane_o <= zp_c;
        zero_cnt_o   <= popcnt8(zp_c);
        tag_o        <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_dbx_encoder.sv
// Directed + random round-trip bench for dbx_encoder; expected data comes from
// hand constants and an independent DBX decode of the observed planes.
module tb_dbx_encoder;
  logic         clk = 1'b0;
  logic         rst, valid_i, ready_i;
  logic         ready_o, valid_o;
  logic [255:0] diff_i, bpx_o;
  logic [3:0]   tag_i, tag_o, zero_cnt_o;
  logic [7:0]   zero_plane_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbx_encoder #(.NUM_SYM(32), .SYM_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .diff_i(diff_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .bpx_o(bpx_o), .zero_plane_o(zero_plane_o), .zero_cnt_o(zero_cnt_o), .tag_o(tag_o)
  );

  // decompressor-side inverse: rebuild raw planes top-down, then scatter back to bytes
  function automatic logic [255:0] dbx_dec(input logic [255:0] x);
    logic [255:0] d;
    logic         p [8][32];
    d = '0;
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 32; r++) begin
        if (k == 0 || r == 0) p[k][r] = x[255-32*k-r];
        else                  p[k][r] = x[255-32*k-r] ^ p[k-1][r];
        d[255-8*r-k] = p[k][r];
      end
    return d;
  endfunction

  function automatic logic [7:0] zflags(input logic [255:0] x);
    logic [7:0] z;
    for (int k = 0; k < 8; k++) z[k] = (x[255-32*k -: 32] == 32'h0);
    return z;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [255:0] d, input logic [3:0] t, input logic r);
    @(negedge clk);
    valid_i = v; diff_i = d; tag_i = t; ready_i = r;
    #1;
  endtask

  // offer one block into an empty pipe with ready_i high; returns at the negedge it is visible
  task automatic send1(input logic [255:0] d, input logic [3:0] t);
    drive(1'b1, d, t, 1'b1);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("lat_s1_only", valid_o, 1'b0);
    drive(1'b0, '0, 4'h0, 1'b1);
  endtask

  logic [255:0] a, b, c, e, cur_d;
  logic [3:0]   cur_t;
  logic [255:0] q_d[$];
  logic [3:0]   q_t[$];
  int           sent, cyc;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; diff_i = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_ready_o", ready_o, 1'b1);
    chk("rst_bpx_o", bpx_o, '0);
    chk("rst_zero_plane", zero_plane_o, 8'h00);
    chk("rst_zero_cnt", zero_cnt_o, 4'd0);
    chk("rst_tag_o", tag_o, 4'h0);

    send1('0, 4'h1);
    chk("zero_valid", valid_o, 1'b1);
    chk("zero_bpx", bpx_o, '0);
    chk("zero_zp", zero_plane_o, 8'hFF);
    chk("zero_cnt", zero_cnt_o, 4'd8);
    chk("zero_tag", tag_o, 4'h1);

    send1({32{8'h01}}, 4'h2);
    chk("b01_bpx", bpx_o, {224'h0, 32'hFFFF_FFFF});
    chk("b01_zp", zero_plane_o, 8'h7F);
    chk("b01_cnt", zero_cnt_o, 4'd7);
    chk("b01_tag", tag_o, 4'h2);

    send1({32{8'h80}}, 4'h3);
    chk("b80_bpx", bpx_o, {32'hFFFF_FFFF, 32'h7FFF_FFFF, 192'h0});
    chk("b80_zp", zero_plane_o, 8'hFC);
    chk("b80_cnt", zero_cnt_o, 4'd6);

    // backpressure: three offered, only two fit while the sink is stalled
    drive(1'b0, '0, 4'h0, 1'b1);
    a = rnd256(); b = rnd256(); c = rnd256();
    drive(1'b1, a, 4'hA, 1'b0);
    chk("bp_acc_a", ready_o, 1'b1);
    drive(1'b1, b, 4'hB, 1'b0);
    chk("bp_acc_b", ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, c, 4'hC, 1'b0);
      chk("bp_full_ready", ready_o, 1'b0);
      chk("bp_hold_valid", valid_o, 1'b1);
      chk("bp_hold_data", dbx_dec(bpx_o), a);
      chk("bp_hold_tag", tag_o, 4'hA);
    end
    drive(1'b1, c, 4'hC, 1'b1);
    chk("bp_rel_ready", ready_o, 1'b1);
    chk("bp_out_a", dbx_dec(bpx_o), a);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("bp_out_b_v", valid_o, 1'b1);
    chk("bp_out_b", dbx_dec(bpx_o), b);
    chk("bp_out_b_tag", tag_o, 4'hB);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("bp_out_c_v", valid_o, 1'b1);
    chk("bp_out_c", dbx_dec(bpx_o), c);
    chk("bp_out_c_tag", tag_o, 4'hC);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("bp_drained", valid_o, 1'b0);

    // reset with both stages full
    drive(1'b1, a, 4'h5, 1'b0);
    drive(1'b1, b, 4'h6, 1'b0);
    @(negedge clk); rst = 1'b1; valid_i = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("mrst_valid_o", valid_o, 1'b0);
    chk("mrst_ready_o", ready_o, 1'b1);
    e = rnd256();
    drive(1'b1, e, 4'h9, 1'b1);
    chk("mrst_no_stale", valid_o, 1'b0);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("mrst_no_stale2", valid_o, 1'b0);
    drive(1'b0, '0, 4'h0, 1'b1);
    chk("mrst_first_v", valid_o, 1'b1);
    chk("mrst_first_d", dbx_dec(bpx_o), e);
    chk("mrst_first_tag", tag_o, 4'h9);
    drive(1'b0, '0, 4'h0, 1'b1);

    // random round trip with random valid/ready
    sent = 0; cyc = 0;
    cur_d = rnd256(); cur_t = 4'($urandom());
    while ((sent < 10000 || q_d.size() != 0) && cyc < 60000) begin
      drive((sent < 10000) && ($urandom_range(3) != 0), cur_d, cur_t, $urandom_range(3) != 0);
      cyc++;
      if (valid_o && ready_i) begin
        if (q_d.size() == 0) chk("rt_spurious", valid_o, 1'b0);
        else begin
          chk("rt_data", dbx_dec(bpx_o), q_d[0]);
          chk("rt_tag", tag_o, q_t[0]);
          chk("rt_zp", zero_plane_o, zflags(bpx_o));
          chk("rt_cnt", zero_cnt_o, 4'($countones(zflags(bpx_o))));
          void'(q_d.pop_front());
          void'(q_t.pop_front());
        end
      end
      if (valid_i && ready_o) begin
        q_d.push_back(cur_d); q_t.push_back(cur_t);
        sent++;
        cur_d = rnd256(); cur_t = 4'($urandom());
      end
    end
    chk("rt_sent", sent, 10000);
    chk("rt_drained", q_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
